// File: rtl/blt_cmd_sched.sv
// blt_cmd_sched: Bluetooth command frame parser and direction scheduler
// for the Snake game core. Frames are 0xA5, CMD, CMD^0xFF.
module blt_cmd_sched #(
  parameter int BYTE_TIMEOUT = 50_000,
  parameter int LINK_TIMEOUT = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ack,
  input  logic [7:0] rx_data,
  input  logic       tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       paused,
  output logic       restart,
  output logic       link_alive,
  output logic [7:0] err_cnt
);

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BW-1:0] BT_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [LW-1:0] LT_LAST = LW'(LINK_TIMEOUT - 1);

  localparam logic [7:0] HDR       = 8'hA5;
  localparam logic [7:0] C_UP      = 8'h01;
  localparam logic [7:0] C_DOWN    = 8'h02;
  localparam logic [7:0] C_LEFT    = 8'h03;
  localparam logic [7:0] C_RIGHT   = 8'h04;
  localparam logic [7:0] C_PAUSE   = 8'h10;
  localparam logic [7:0] C_RESTART = 8'h20;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_CMD = 2'd1,
    S_CHK = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      cmd_r;
  logic [BW-1:0]   byte_tmr;
  logic [LW-1:0]   link_cnt;

  logic [1:0]      q_mem [4];
  logic [1:0]      wptr;
  logic [1:0]      rptr;
  logic [2:0]      count;

  logic            is_dir;
  logic            is_pause;
  logic            is_rst;
  logic            chk_hit;
  logic            chk_ok;
  logic            good;
  logic            bad;
  logic            tmo;
  logic            do_rst;
  logic            do_pause;
  logic            dir_cmd;
  logic [1:0]      push_val;
  logic [1:0]      tail_idx;
  logic [1:0]      ref_dir;
  logic            rev;
  logic            do_pop;
  logic            do_push;

  // Classify the latched command byte.
  always_comb begin
    is_dir   = 1'b0;
    is_pause = 1'b0;
    is_rst   = 1'b0;
    case (cmd_r)
      C_UP, C_DOWN, C_LEFT, C_RIGHT: is_dir = 1'b1;
      C_PAUSE:   is_pause = 1'b1;
      C_RESTART: is_rst   = 1'b1;
      default: ;
    endcase
  end

  // Frame verdict, byte timeout and queue push/pop decisions.
  always_comb begin
    chk_hit  = rx_ack && (state == S_CHK);
    chk_ok   = (rx_data == ~cmd_r);
    good     = chk_hit && chk_ok && (is_dir || is_pause || is_rst);
    bad      = chk_hit && !good;
    tmo      = !rx_ack && (state != S_HDR) && (byte_tmr == BT_LAST);
    do_rst   = good && is_rst;
    do_pause = good && is_pause && !game_over;
    dir_cmd  = good && is_dir && !game_over;
    push_val = cmd_r[1:0] - 2'd1;
    tail_idx = wptr - 2'd1;
    ref_dir  = (count != 3'd0) ? q_mem[tail_idx] : dir;
    // Same direction or its reverse share bit 1.
    rev      = (push_val[1] == ref_dir[1]);
    do_pop   = tick && !paused && (count != 3'd0) && !do_rst;
    do_push  = dir_cmd && !rev && ((count != 3'd4) || do_pop);
  end

  // Parser FSM, inter-byte timer and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      cmd_r    <= 8'h00;
      byte_tmr <= '0;
      err_cnt  <= 8'h00;
    end else begin
      if (rx_ack || state == S_HDR || tmo) begin
        byte_tmr <= '0;
      end else begin
        byte_tmr <= byte_tmr + 1'b1;
      end
      if ((bad || tmo) && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'h01;
      end
      if (tmo) begin
        state <= S_HDR;
      end else if (rx_ack) begin
        case (state)
          S_HDR: begin
            if (rx_data == HDR) begin
              state <= S_CMD;
            end
          end
          S_CMD: begin
            cmd_r <= rx_data;
            state <= S_CHK;
          end
          S_CHK: begin
            state <= S_HDR;
          end
          default: begin
            state <= S_HDR;
          end
        endcase
      end
    end
  end

  // Pause level, restart pulse and link-health watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      paused     <= 1'b0;
      restart    <= 1'b0;
      link_alive <= 1'b0;
      link_cnt   <= '0;
    end else begin
      restart <= do_rst;
      if (do_rst) begin
        paused <= 1'b0;
      end else if (do_pause) begin
        paused <= ~paused;
      end
      if (good) begin
        link_alive <= 1'b1;
        link_cnt   <= '0;
      end else if (link_alive) begin
        if (link_cnt == LT_LAST) begin
          link_alive <= 1'b0;
          link_cnt   <= '0;
        end else begin
          link_cnt <= link_cnt + 1'b1;
        end
      end
    end
  end

  // Direction FIFO; a pop reads the pre-push head so a full queue can
  // take a push in the same cycle it releases one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
      dir   <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        q_mem[i] <= 2'd0;
      end
    end else if (do_rst) begin
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
      dir   <= 2'd3;
    end else begin
      if (do_push) begin
        q_mem[wptr] <= push_val;
        wptr        <= wptr + 2'd1;
      end
      if (do_pop) begin
        dir  <= q_mem[rptr];
        rptr <= rptr + 2'd1;
      end
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

endmodule

// File: tb/tb_blt_cmd_sched.sv
// tb_blt_cmd_sched: table-driven frame/tick vectors plus directed
// sequences for restart, same-cycle events, timeouts and saturation.
module tb_blt_cmd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tick = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] dir;
  logic       paused;
  logic       restart;
  logic       link_alive;
  logic [7:0] err_cnt;

  int total = 0;
  int bad = 0;

  blt_cmd_sched #(
    .BYTE_TIMEOUT(100),
    .LINK_TIMEOUT(1000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .tick(tick),
    .game_over(game_over),
    .dir(dir),
    .paused(paused),
    .restart(restart),
    .link_alive(link_alive),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic       go;
    int         nt;
    logic [1:0] d;
    logic       p;
    logic [7:0] e;
    logic       l;
  } vec_t;

  vec_t tv [26];

  function automatic vec_t mk(int nb, logic [7:0] b0, logic [7:0] b1,
                              logic [7:0] b2, logic go, int nt,
                              logic [1:0] d, logic p, logic [7:0] e,
                              logic l);
    vec_t v;
    v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.go = go;
    v.nt = nt; v.d = d; v.p = p; v.e = e; v.l = l;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    @(negedge clk);
    rx_ack  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_ack  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(logic [7:0] c);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(~c);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  // Last byte of a frame with a tick landing in the same cycle.
  task automatic chk_with_tick(logic [7:0] c);
    send_byte(8'hA5);
    send_byte(c);
    @(negedge clk);
    rx_ack  = 1'b1;
    rx_data = ~c;
    tick    = 1'b1;
    @(negedge clk);
    rx_ack  = 1'b0;
    tick    = 1'b0;
  endtask

  initial begin
    tv[0]  = mk(3, 8'hA5, 8'h03, 8'hFC, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[1]  = mk(3, 8'hA5, 8'h04, 8'hFB, 0, 2, 2'd3, 0, 8'd0, 1);
    tv[2]  = mk(3, 8'hA5, 8'h01, 8'hFE, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[3]  = mk(3, 8'hA5, 8'h02, 8'hFD, 0, 1, 2'd0, 0, 8'd0, 1);
    tv[4]  = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd0, 0, 8'd0, 1);
    tv[5]  = mk(3, 8'hA5, 8'h20, 8'hDF, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[6]  = mk(3, 8'hA5, 8'h01, 8'hFE, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[7]  = mk(3, 8'hA5, 8'h04, 8'hFB, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[8]  = mk(3, 8'hA5, 8'h02, 8'hFD, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[9]  = mk(3, 8'hA5, 8'h03, 8'hFC, 0, 0, 2'd3, 0, 8'd0, 1);
    tv[10] = mk(3, 8'hA5, 8'h01, 8'hFE, 0, 1, 2'd0, 0, 8'd0, 1);
    tv[11] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd3, 0, 8'd0, 1);
    tv[12] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd1, 0, 8'd0, 1);
    tv[13] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd2, 0, 8'd0, 1);
    tv[14] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd2, 0, 8'd0, 1);
    tv[15] = mk(3, 8'hA5, 8'h01, 8'h00, 0, 0, 2'd2, 0, 8'd1, 1);
    tv[16] = mk(3, 8'hA5, 8'h55, 8'hAA, 0, 0, 2'd2, 0, 8'd2, 1);
    tv[17] = mk(1, 8'h33, 8'h00, 8'h00, 0, 0, 2'd2, 0, 8'd2, 1);
    tv[18] = mk(3, 8'hA5, 8'h10, 8'hEF, 0, 0, 2'd2, 1, 8'd2, 1);
    tv[19] = mk(3, 8'hA5, 8'h01, 8'hFE, 0, 1, 2'd2, 1, 8'd2, 1);
    tv[20] = mk(3, 8'hA5, 8'h10, 8'hEF, 0, 1, 2'd0, 0, 8'd2, 1);
    tv[21] = mk(3, 8'hA5, 8'h04, 8'hFB, 1, 1, 2'd0, 0, 8'd2, 1);
    tv[22] = mk(3, 8'hA5, 8'h10, 8'hEF, 1, 0, 2'd0, 0, 8'd2, 1);
    tv[23] = mk(3, 8'hA5, 8'h20, 8'hDF, 1, 0, 2'd3, 0, 8'd2, 1);
    tv[24] = mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 2'd3, 0, 8'd2, 1);
    tv[25] = mk(3, 8'hA5, 8'hA5, 8'h5A, 0, 0, 2'd3, 0, 8'd3, 1);

    do_reset();
    chk("rst_dir", {6'd0, dir}, 8'd3);
    chk("rst_paused", {7'd0, paused}, 8'd0);
    chk("rst_restart", {7'd0, restart}, 8'd0);
    chk("rst_link", {7'd0, link_alive}, 8'd0);
    chk("rst_err", err_cnt, 8'd0);

    for (int i = 0; i < 26; i++) begin
      game_over = tv[i].go;
      if (tv[i].nb > 0) send_byte(tv[i].b0);
      if (tv[i].nb > 1) send_byte(tv[i].b1);
      if (tv[i].nb > 2) send_byte(tv[i].b2);
      for (int t = 0; t < tv[i].nt; t++) do_tick();
      chk($sformatf("v%0d_dir", i), {6'd0, dir}, {6'd0, tv[i].d});
      chk($sformatf("v%0d_paused", i), {7'd0, paused}, {7'd0, tv[i].p});
      chk($sformatf("v%0d_err", i), err_cnt, tv[i].e);
      chk($sformatf("v%0d_link", i), {7'd0, link_alive}, {7'd0, tv[i].l});
      game_over = 1'b0;
    end

    // Restart is a single-cycle pulse after the CHK byte.
    do_reset();
    send_frame(8'h01);
    send_frame(8'h10);
    send_byte(8'hA5);
    send_byte(8'h20);
    @(negedge clk);
    rx_ack  = 1'b1;
    rx_data = 8'hDF;
    @(negedge clk);
    rx_ack  = 1'b0;
    chk("restart_hi", {7'd0, restart}, 8'd1);
    chk("restart_unpause", {7'd0, paused}, 8'd0);
    @(negedge clk);
    chk("restart_lo", {7'd0, restart}, 8'd0);
    do_tick();
    chk("restart_flush", {6'd0, dir}, 8'd3);

    // Tick in the CHK cycle cannot pop the entry being pushed.
    do_reset();
    chk_with_tick(8'h01);
    chk("same_cyc_nopop", {6'd0, dir}, 8'd3);
    do_tick();
    chk("same_cyc_later", {6'd0, dir}, 8'd0);

    // Push into a full queue while popping.
    do_reset();
    send_frame(8'h01);
    send_frame(8'h04);
    send_frame(8'h02);
    send_frame(8'h03);
    chk_with_tick(8'h01);
    chk("full_pp_pop", {6'd0, dir}, 8'd0);
    do_tick();
    chk("full_pp_1", {6'd0, dir}, 8'd3);
    do_tick();
    chk("full_pp_2", {6'd0, dir}, 8'd1);
    do_tick();
    chk("full_pp_3", {6'd0, dir}, 8'd2);
    do_tick();
    chk("full_pp_4", {6'd0, dir}, 8'd0);

    // Popping the only entry: popped value is the reference.
    do_reset();
    send_frame(8'h01);
    chk_with_tick(8'h02);
    chk("last_pop", {6'd0, dir}, 8'd0);
    do_tick();
    chk("last_pop_drop", {6'd0, dir}, 8'd0);

    // Inter-byte timeout drops the frame and counts an error.
    do_reset();
    send_byte(8'hA5);
    idle(150);
    chk("tmo_err", err_cnt, 8'd1);
    send_frame(8'h01);
    do_tick();
    chk("tmo_recover_dir", {6'd0, dir}, 8'd0);
    chk("tmo_recover_err", err_cnt, 8'd1);

    // Link watchdog.
    do_reset();
    send_frame(8'h04);
    idle(990);
    chk("link_still", {7'd0, link_alive}, 8'd1);
    idle(20);
    chk("link_drop", {7'd0, link_alive}, 8'd0);

    // Reset mid-frame: no partial frame survives.
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    do_reset();
    send_byte(8'hFD);
    chk("midrst_err", err_cnt, 8'd0);
    chk("midrst_link", {7'd0, link_alive}, 8'd0);
    send_frame(8'h02);
    do_tick();
    chk("midrst_after", {6'd0, dir}, 8'd1);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 254; i++) begin
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
    end
    chk("err_254", err_cnt, 8'd254);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h00);
    end
    chk("err_sat", err_cnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blt_cmd_sched.md
# blt_cmd_sched

Command controller between the Bluetooth UART receiver and the Snake game core. It parses 3-byte command frames from the receiver's byte/ack stream and filters direction commands against snake-reversal rules. Accepted directions go into a 4-entry queue, released one per game tick; pause, restart and link-health status are also produced here for the game core.

## Interface
- BYTE_TIMEOUT, 50_000: max clk cycles between bytes inside one frame (1 ms at 50 MHz).
- LINK_TIMEOUT, 50_000_000: clk cycles after the last valid frame before link_alive drops (1 s).
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_ack  in  1  one-cycle pulse from the UART receiver: byte complete.
- rx_data  in  8  received byte, valid in the rx_ack cycle.
- tick  in  1  one-cycle game-step pulse from the game timer.
- game_over  in  1  level; game core is in the game-over state.
- dir  out  2  current snake direction: 0 up, 1 down, 2 left, 3 right.
- paused  out  1  level; game stepping is suspended.
- restart  out  1  one-cycle pulse requesting a game restart.
- link_alive  out  1  valid frame seen within LINK_TIMEOUT.
- err_cnt  out  8  saturating count of rejected frames.

## Operation
- Frame format: 0xA5, CMD, CHK, where CHK = CMD ^ 0xFF.
- Parser FSM: S_HDR, S_CMD, S_CHK.
  - S_HDR: byte 0xA5 goes to S_CMD; any other byte is discarded silently (no error count).
  - S_CMD: latch CMD and go to S_CHK.
  - S_CHK: go to S_HDR. If CHK matches and CMD is known, execute CMD; otherwise err_cnt +1.
- Byte timer: resets on every rx_ack. If it reaches BYTE_TIMEOUT while in S_CMD or S_CHK, return to S_HDR and increment err_cnt.
- err_cnt saturates at 255.
- Commands:
  - 0x01 up, 0x02 down, 0x03 left, 0x04 right: direction push.
  - 0x10: toggle paused.
  - 0x20: restart.
  - Any other value is an unknown command and is rejected.
- Direction push:
  - Reference direction = queue tail if count > 0, else dir.
  - Drop the push if it equals the reference or is opposite to it. Opposite means same dir[1] and different dir[0].
  - Drop the push if the queue is full and no pop happens in the same cycle.
  - Drops are silent and do not count as errors.
  - While game_over = 1, direction pushes and pause toggles are ignored.
- Queue: 4 entries, 2 bits wide, FIFO.
- Pop: on tick with paused = 0 and count > 0, dir takes the head entry. A tick with paused = 1 or an empty queue leaves dir unchanged.
- Simultaneous push and pop: the pop uses the pre-push head. A push to a full queue succeeds and count stays 4. When the only entry is popped in the same cycle, the popped value is the reference, which equals the new dir.
- Restart (accepted even when game_over = 1):
  - restart pulses for one cycle.
  - Queue flushed; dir set to 3; paused set to 0.
  - A tick in the same cycle is ignored.
- link_alive: set on every valid known frame and the link counter reloads. Cleared when the counter reaches LINK_TIMEOUT.

## Timing
- Reset values: dir = 3, paused = 0, restart = 0, link_alive = 0, err_cnt = 0, queue empty, FSM in S_HDR, both timers 0.
- rx_ack on the CHK byte:
  - paused, restart, link_alive and err_cnt update on the next clk edge, i.e. visible 1 cycle later.
  - The queue entry is visible 1 cycle later.
- tick to dir: dir changes 1 cycle after the tick cycle.
- Latency from a CHK byte to dir, with an empty queue: earliest is the first tick occurring 1 or more cycles after the CHK ack. A tick in the same cycle as the CHK ack does not pop the new entry.
- rst mid-frame or mid-pause: everything returns to reset values at the next edge. No partial frame survives.
- rx_ack pulses are at least 2 cycles apart (UART rate). The block needs no input buffering.

## Test plan
- Valid frame A5 01 FE, then tick → dir goes from 3 to 0 one cycle after the tick; err_cnt = 0; link_alive = 1.
- Reversal and duplicate: from dir = 3, send left (A5 03 FC) then right (A5 04 FB), then 2 ticks → both pushes dropped, dir stays 3, err_cnt = 0. Then send up (01) and down (02), then 2 ticks → only up queued (down is opposite of the tail), dir = 0 after the first tick.
- Queue full: send up, right, down, left, up; no ticks; 5 ticks after → dir sequence 0, 3, 1, 2, then unchanged (fifth push dropped).
- Errors: A5 01 00 → err_cnt = 1. A5 55 AA → err_cnt = 2. A5 followed by silence with BYTE_TIMEOUT = 100 → err_cnt = 3 and FSM back in S_HDR; a next valid frame is accepted.
- Pause/restart: pause frame (10 EF), queue up, tick → dir unchanged. Restart frame (20 DF) → restart high 1 cycle, paused = 0, queue empty, dir = 3.
- Link timeout, LINK_TIMEOUT = 1000: valid frame then 1000 idle cycles → link_alive drops to 0. game_over = 1: direction frame → ignored; restart frame → accepted.
